// File: rtl/multi_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_master_arbiter_if
// Description : Request/grant bundle between the cores and the bus arbiter.
//               GRANT_COUNT exists only when ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_master_arbiter_if #(
  parameter int NumOfRequesters = 4
);
  localparam int IdWidth = $clog2(NumOfRequesters);

  logic [NumOfRequesters-1:0] REQ;
  logic [NumOfRequesters-1:0] DONE;
  logic [NumOfRequesters-1:0] ACCESS;
  logic [IdWidth-1:0]         GRANT_ID;
  logic                       GRANT_VALID;
  logic                       PREEMPT;
`ifdef ARB_STATS_EN
  logic [16*NumOfRequesters-1:0] GRANT_COUNT;
`endif

  modport master (
    output REQ,
    output DONE,
`ifdef ARB_STATS_EN
    input  GRANT_COUNT,
`endif
    input  ACCESS,
    input  GRANT_ID,
    input  GRANT_VALID,
    input  PREEMPT
  );

  modport slave (
    input  REQ,
    input  DONE,
`ifdef ARB_STATS_EN
    output GRANT_COUNT,
`endif
    output ACCESS,
    output GRANT_ID,
    output GRANT_VALID,
    output PREEMPT
  );
endinterface
`default_nettype wire

// File: rtl/multi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multi_master_arbiter
// Description : N-master bus arbiter, fixed-priority or round-robin, with
//               release handshake and bounded hold time. Define ARB_STATS_EN
//               to add per-master saturating grant counters (GRANT_COUNT).
// Revision    : 1.0 - initial release
// ============================================================================
module multi_master_arbiter #(
  parameter int NumOfRequesters = 4,
  parameter int RoundRobin      = 1,
  parameter int MaxHoldCycles   = 16
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  multi_master_arbiter_if.slave bus
);
  localparam int         IdWidth     = $clog2(NumOfRequesters);
  localparam logic [7:0] c_HOLD_LAST = (MaxHoldCycles == 0) ? 8'd0 : 8'(MaxHoldCycles - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                     r_state;
  logic [NumOfRequesters-1:0] r_access;
  logic [IdWidth-1:0]         r_id;
  logic                       r_valid;
  logic                       r_preempt;
  logic [7:0]                 r_hold;
  logic [IdWidth-1:0]         r_last;

  logic                       w_rel_drop;
  logic                       w_rel_done;
  logic                       w_rel_timeout;
  logic                       w_release;
  logic                       w_grant;
  logic [NumOfRequesters-1:0] w_cand;
  logic [IdWidth-1:0]         w_base;
  logic                       w_win_valid;
  logic [IdWidth-1:0]         w_win_id;
  logic [NumOfRequesters-1:0] w_win_oh;

  always_comb begin
    w_rel_drop    = |(r_access & ~bus.REQ);
    w_rel_done    = |(r_access & bus.DONE);
    w_rel_timeout = (MaxHoldCycles != 0) && (r_hold == c_HOLD_LAST);
    w_release     = (r_state == ST_OWNED) && (w_rel_drop || w_rel_done || w_rel_timeout);
    // r_access is zero in IDLE, so this masks only the outgoing owner.
    w_cand        = bus.REQ & ~r_access;
    w_base        = (r_state == ST_OWNED) ? r_id : r_last;
  end

  always_comb begin : winner_select
    int v_idx;
    v_idx       = 0;
    w_win_valid = 1'b0;
    w_win_id    = '0;
    for (int k = 0; k < NumOfRequesters; k++) begin
      if (RoundRobin != 0) begin
        v_idx = int'(w_base) + 1 + k;
        if (v_idx >= NumOfRequesters) begin
          v_idx = v_idx - NumOfRequesters;
        end
      end else begin
        v_idx = k;
      end
      if (!w_win_valid && w_cand[v_idx[IdWidth-1:0]]) begin
        w_win_valid = 1'b1;
        w_win_id    = v_idx[IdWidth-1:0];
      end
    end
    w_win_oh = w_win_valid ? (NumOfRequesters'(1) << w_win_id) : '0;
    w_grant  = w_win_valid && ((r_state == ST_IDLE) || w_release);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_access  <= '0;
      r_id      <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
      r_hold    <= 8'd0;
      r_last    <= IdWidth'(NumOfRequesters - 1);
    end else begin
      r_preempt <= w_release && w_rel_timeout && !w_rel_drop && !w_rel_done;
      if (w_release) begin
        r_last <= r_id;
      end
      if (w_grant) begin
        r_state  <= ST_OWNED;
        r_access <= w_win_oh;
        r_id     <= w_win_id;
        r_valid  <= 1'b1;
        r_hold   <= 8'd0;
      end else if (w_release) begin
        r_state  <= ST_IDLE;
        r_access <= '0;
        r_id     <= '0;
        r_valid  <= 1'b0;
        r_hold   <= 8'd0;
      end else if ((r_state == ST_OWNED) && (r_hold != 8'hFF)) begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  assign bus.ACCESS      = r_access;
  assign bus.GRANT_ID    = r_id;
  assign bus.GRANT_VALID = r_valid;
  assign bus.PREEMPT     = r_preempt;

`ifdef ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < NumOfRequesters; gi++) begin : g_stats
      logic [15:0] r_count;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_count <= 16'd0;
        end else if (w_grant && w_win_oh[gi] && (r_count != 16'hFFFF)) begin
          r_count <= r_count + 16'd1;
        end
      end
      assign bus.GRANT_COUNT[16*gi +: 16] = r_count;
    end
  endgenerate
`endif
endmodule
`default_nettype wire

// File: doc/multi_master_arbiter.md
Name: multi_master_arbiter

Overview:
Parametrised successor to the shared-bus arbiter. Grants one of NumOfRequesters masters exclusive access to the shared memory/bus port. Selectable fixed-priority or round-robin policy, explicit release handshake, and a bounded hold time so one core cannot starve the others. Sits between the core request lines and the bus mux; ACCESS drives the mux select and the per-core grant.

Parameters:
NumOfRequesters, 4, number of masters; legal range 2..16.
RoundRobin, 1, 1 = round-robin starting after the last owner; 0 = fixed priority, lowest index wins.
MaxHoldCycles, 16, maximum consecutive cycles one owner may hold the grant; 0 = unlimited; legal range 0..255.
IdWidth, $clog2(NumOfRequesters), width of GRANT_ID; derived, never overridden.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous, active-high reset.
REQ  input  NumOfRequesters  level request per master; held high until granted and finished.
DONE  input  NumOfRequesters  single-cycle release pulse from the current owner; ignored from non-owners.
ACCESS  output  NumOfRequesters  registered one-hot grant; all-zero when idle.
GRANT_ID  output  IdWidth  binary index of the owner; valid only when GRANT_VALID = 1.
GRANT_VALID  output  1  high while any grant is active; equals the OR of ACCESS.
PREEMPT  output  1  single-cycle pulse on the cycle a grant is removed by hold timeout.

Behaviour:
- Reset (RST high at posedge):
  - ACCESS = 0, GRANT_ID = 0, GRANT_VALID = 0, PREEMPT = 0.
  - Hold counter = 0; last_owner = NumOfRequesters-1, so round-robin first favours index 0.
  - Reset has priority over every other event, including mid-grant; the grant drops on that edge.
- States: IDLE, OWNED.
- IDLE:
  - If REQ != 0 at a posedge, select a winner and enter OWNED.
  - ACCESS, GRANT_ID and GRANT_VALID are visible one cycle after REQ is first sampled.
  - If REQ == 0, stay in IDLE with outputs zero.
- Winner selection:
  - RoundRobin = 1: scan indices last_owner+1, last_owner+2, ... with modulo-N wrap. First set REQ bit wins.
  - RoundRobin = 0: lowest set index wins.
  - A requester excluded by a timeout on the same edge is skipped in either mode. If it is the only requester, the result is no winner.
- OWNED, release conditions evaluated at each posedge:
  - (a) REQ[owner] = 0;
  - (b) DONE[owner] = 1;
  - (c) MaxHoldCycles != 0 and hold counter == MaxHoldCycles-1.
- Release handling:
  - On release, last_owner <= owner, and the next winner is selected on the same edge from REQ with the owner masked out. This is a zero-dead-cycle handover.
  - If no other requester exists, go to IDLE with ACCESS = 0 for at least one cycle, then re-arbitrate normally.
  - Condition (c) also pulses PREEMPT for one cycle. If (a) or (b) occurs on the same edge, there is no PREEMPT.
- Hold counter:
  - 8-bit; cleared on each new grant; increments each OWNED cycle without release.
  - Saturates rather than wraps when MaxHoldCycles = 0.
- While OWNED with no release, ACCESS is unchanged regardless of other REQ changes. There is no mid-grant preemption by higher priority.
- DONE from a non-owner, or DONE while IDLE: ignored.
- Invariants:
  - ACCESS is always one-hot or zero.
  - GRANT_ID is consistent with ACCESS.
  - ACCESS[i] only rises if REQ[i] was high at the granting edge.

Optional Feature:
ARB_STATS_EN
- Defined: adds output GRANT_COUNT, width 16*NumOfRequesters. Slice i is a saturating count (max 0xFFFF) of grants issued to master i. It increments on the edge ACCESS[i] rises, including back-to-back re-grants after IDLE. Cleared by RST.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then REQ=4'b0100 -> ACCESS=4'b0100, GRANT_ID=2, GRANT_VALID=1 one cycle later; all outputs 0 during reset.
- RoundRobin=1, REQ=4'b1111 held, DONE pulsed by each owner -> grant order 0,1,2,3,0 with no idle cycle between grants.
- RoundRobin=0, REQ=4'b1010 -> ACCESS=4'b0010. Owner drops REQ[1] -> ACCESS=4'b1000 on the same edge it is sampled.
- MaxHoldCycles=4, owner 0 keeps REQ high with REQ=4'b0011 -> ACCESS[0] high exactly 4 cycles, PREEMPT pulses once, ACCESS=4'b0010 next. With REQ=4'b0001 alone: ACCESS goes 0 for one cycle, then 4'b0001 again.
- DONE=4'b0100 from a non-owner while owner 1 holds -> no change. RST asserted mid-grant -> ACCESS=0 next edge, then round-robin restarts at index 0.
- ARB_STATS_EN defined, 3 grants to master 2 -> GRANT_COUNT slice 2 = 3, other slices unchanged.
